muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide engine for the EX stage of the RISC-V pipeline CPU. It accepts one M-extension operation from EX and sequences a shift-add multiply or a restoring divide over 32 iterations. While the operation runs it stalls the pipeline front end, then presents a registered 32-bit result for the EX→MEM register to capture.

---
 rtl/muldiv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine for the EX stage.
// Shift-add multiply or restoring divide, one bit per cycle over DATA_W cycles.
// Divide by zero and signed overflow bypass the iteration and complete in one cycle.
module muldiv_sequencer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        fn3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [2:0]          r_fn3;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;      // product high half / partial remainder
    logic [DATA_W-1:0]   r_lo;      // multiplier -> product low half / dividend -> quotient
    logic [DATA_W-1:0]   r_mc;      // multiplicand / divisor magnitude
    logic                r_neg_q;   // product or quotient must be negated
    logic                r_neg_r;   // remainder must be negated
    logic                r_done;
    logic [DATA_W-1:0]   r_result;

    logic                w_accept;
    logic                w_last;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [DATA_W-1:0]   w_mag_a;
    logic [DATA_W-1:0]   w_mag_b;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [DATA_W-1:0]   w_special_res;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_shift;
    logic                w_ge;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_hi_nx;
    logic [DATA_W-1:0]   w_lo_nx;
    logic [PROD_W-1:0]   w_prod;
    logic [PROD_W-1:0]   w_prod_s;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic [DATA_W-1:0]   w_final;

    // Operation acceptance, operand signedness and magnitudes
    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_last     = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_a_signed = (fn3 == 3'b001) || (fn3 == 3'b010) || (fn3 == 3'b100) || (fn3 == 3'b110);
    assign w_b_signed = (fn3 == 3'b001) || (fn3 == 3'b100) || (fn3 == 3'b110);
    assign w_a_neg    = w_a_signed && op_a[DATA_W-1];
    assign w_b_neg    = w_b_signed && op_b[DATA_W-1];
    assign w_mag_a    = w_a_neg ? (DATA_W'(0) - op_a) : op_a;
    assign w_mag_b    = w_b_neg ? (DATA_W'(0) - op_b) : op_b;

    // Divide corner cases resolved without iterating
    assign w_div_zero    = fn3[2] && (op_b == '0);
    assign w_ovf         = fn3[2] && !fn3[0] && (op_a == MIN_NEG) && (op_b == '1);
    assign w_special     = w_div_zero || w_ovf;
    assign w_special_res = w_div_zero ? (fn3[1] ? op_a : '1)
                                      : (fn3[1] ? '0 : MIN_NEG);

    // One shift-add step and one restoring-divide step
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
    assign w_shift = {r_hi, r_lo[DATA_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mc});
    assign w_diff  = w_shift[DATA_W-1:0] - r_mc;

    // Select the iteration step for the latched operation
    always_comb begin
        w_hi_nx = w_sum[DATA_W:1];
        w_lo_nx = {w_sum[0], r_lo[DATA_W-1:1]};
        if (r_fn3[2]) begin
            if (w_ge) begin
                w_hi_nx = w_diff;
                w_lo_nx = {r_lo[DATA_W-2:0], 1'b1};
            end else begin
                w_hi_nx = w_shift[DATA_W-1:0];
                w_lo_nx = {r_lo[DATA_W-2:0], 1'b0};
            end
        end
    end

    // Sign fix and result-half selection applied to the final iteration
    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg_q ? (PROD_W'(0) - w_prod) : w_prod;
    assign w_quo    = r_neg_q ? (DATA_W'(0) - w_lo_nx) : w_lo_nx;
    assign w_rem    = r_neg_r ? (DATA_W'(0) - w_hi_nx) : w_hi_nx;
    assign w_final  = r_fn3[2] ? (r_fn3[1] ? w_rem : w_quo)
                               : ((r_fn3[1:0] == 2'b00) ? w_prod_s[DATA_W-1:0]
                                                        : w_prod_s[PROD_W-1:DATA_W]);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; flush wins over everything
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !flush) begin
                    w_state_nx = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_state_nx = S_IDLE;
                end else if (w_last) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fn3    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mc     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_fn3   <= fn3;
                r_cnt   <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                r_hi    <= '0;
                r_lo    <= fn3[2] ? w_mag_a : w_mag_b;
                r_mc    <= fn3[2] ? w_mag_b : w_mag_a;
                if (w_special) begin
                    r_result <= w_special_res;
                    r_done   <= 1'b1;
                end
            end else if ((r_state == S_CALC) && !flush) begin
                r_hi  <= w_hi_nx;
                r_lo  <= w_lo_nx;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign stall  = w_accept || (r_state == S_CALC);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, result and latency checks.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  fn3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    typedef struct {
        int          id;
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_done = 0;
    int          prev_done_cyc = 0;
    int          last_done_cyc = 0;
    int          op_id = 0;
    logic [31:0] last_res = 32'h0;

    muldiv_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fn3    (fn3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_done", result, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(result === e.res, $sformatf("op%0d_result", e.id), result, e.res);
                chk(cyc == e.cyc, $sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one op, scramble inputs after acceptance, check stall profile until done
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int t0;
        int bad_cyc;
        bit seen;
        @(negedge clk);
        start = 1'b1; fn3 = f; op_a = a; op_b = b;
        t0 = cyc;
        op_id++;
        exp_q.push_back('{op_id, exp, t0 + lat});
        last_res = exp;
        bad_cyc = -1;
        seen = 1'b0;
        for (int i = 0; i < lat + 10 && !seen; i++) begin
            #1;
            if ((stall !== (cyc < t0 + lat)) && bad_cyc < 0) bad_cyc = cyc - t0;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                start = 1'b0;
                fn3   = 3'($urandom);
                op_a  = $urandom;
                op_b  = $urandom;
            end
        end
        start = 1'b0;
        chk(bad_cyc < 0, $sformatf("op%0d_stall_profile(offset)", op_id), 32'(bad_cyc), 32'hFFFF_FFFF);
        chk(seen, $sformatf("op%0d_done_seen", op_id), 32'(seen), 32'h1);
    endtask

    initial begin
        int t0;
        int nd;
        rst_n = 1'b0; start = 1'b0; fn3 = 3'b000; op_a = '0; op_b = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk(done === 1'b0, "reset_done", 32'(done), 32'h0);
        chk(result === 32'h0, "reset_result", result, 32'h0);
        chk(stall === 1'b0, "reset_stall", 32'(stall), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Multiplies
        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);

        // Signed division back-to-back
        run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        @(negedge clk);
        chk(last_done_cyc - prev_done_cyc == 34, "back_to_back_gap",
            32'(last_done_cyc - prev_done_cyc), 32'd34);

        // Flush during CALC: no completion, result held
        @(negedge clk);
        start = 1'b1; fn3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        t0 = cyc;
        nd = n_done;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk(stall === 1'b0, "flush_stall_low", 32'(stall), 32'h0);
        chk(result === last_res, "flush_result_held", result, last_res);
        repeat (40) @(negedge clk);
        chk(n_done == nd, "flush_no_done", 32'(n_done - nd), 32'h0);
        chk(result === last_res, "flush_result_still_held", result, last_res);
        run_op(3'b000, 32'd3, 32'd4, 32'd12, 33);

        // Special cases
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op(3'b111, 32'd5, 32'd0, 32'd5, 1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; fn3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk(done === 1'b0, "midreset_done", 32'(done), 32'h0);
        chk(result === 32'h0, "midreset_result", result, 32'h0);
        chk(stall === 1'b0, "midreset_stall", 32'(stall), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33);

        repeat (5) @(negedge clk);
        chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
